data_memory_arbiter: RTL and testbench
======================================

# data_memory_arbiter

Two-port arbiter and sequencer that shares the single-port data memory between the processor's load/store unit (port 0) and a secondary bus master such as a program/data loader (port 1). It accepts requests with a req/gnt handshake, registers the winning request, and drives the memory's write/read/address/data inputs for exactly one access cycle. It captures the read data and returns it with a one-cycle valid pulse. It sits between the two masters and the data memory.

## Interface
- DATA_WIDTH, 32, width of address and data buses
- BASE_ADDR, 32'h10010000, first byte address of the data memory window
- MEM_BYTES, 32768, size of the window in bytes (8192 words)

- clk  input  1  system clock, rising edge
- reset  input  1  asynchronous, active-low reset
- m0_req_i / m1_req_i  input  1  request; held with its fields until gnt
- m0_we_i / m1_we_i  input  1  1 = write, 0 = read
- m0_addr_i / m1_addr_i  input  DATA_WIDTH  byte address
- m0_wdata_i / m1_wdata_i  input  DATA_WIDTH  write data
- m0_gnt_o / m1_gnt_o  output  1  one-cycle pulse: request accepted this cycle
- m0_rvalid_o / m1_rvalid_o  output  1  one-cycle pulse: response (read or write) complete
- m0_err_o / m1_err_o  output  1  qualifies rvalid: access rejected
- m0_rdata_o / m1_rdata_o  output  DATA_WIDTH  read data, valid with rvalid
- mem_write_o  output  1  to memory write enable
- mem_read_o  output  1  to memory read enable
- mem_addr_o  output  DATA_WIDTH  byte address to memory, unmodified
- mem_wdata_o  output  DATA_WIDTH  write data to memory
- mem_rdata_i  input  DATA_WIDTH  combinational read data from memory

## Operation
- States: IDLE, ACCESS, RESP. Reset state: IDLE.
- IDLE/RESP: if any req is high, pick the winner, assert its gnt combinationally, latch we/addr/wdata/owner, and go to ACCESS. Otherwise go to IDLE.
- Arbitration is round-robin on a last-owner pointer.
  - Both requesting: grant the port that is not the last owner.
  - Single requester: that port wins.
  - Pointer reset value = port 1, so port 0 wins the first tie.
- ACCESS: drive mem_addr_o/mem_wdata_o from the latched fields.
  - mem_write_o = we, mem_read_o = !we, both gated by the range check.
  - Memory write happens at the edge that ends ACCESS.
  - mem_rdata_i is captured into the response register at the same edge.
  - Next state: RESP.
- RESP: owner's rvalid = 1 and err per the check. rdata = captured data for a good read; rdata = 0 for a write or an error. Arbitration runs in the same cycle.
- Non-owner's rvalid/err/rdata are 0 at all times.
- mem_* outputs are 0 outside ACCESS.
- Range check (see Configuration): error if addr < BASE_ADDR, addr ≥ BASE_ADDR+MEM_BYTES, or addr[1:0] ≠ 0. An erroring access drives mem_write_o = mem_read_o = 0 in ACCESS; no memory side effect.
- A req dropped before gnt is a protocol violation; behaviour is undefined.

## Timing
- Cycle N: gnt. Cycle N+1: ACCESS. Cycle N+2: rvalid. Latency is 2 cycles from gnt.
- Back-to-back throughput: one access per 2 cycles, because a gnt may coincide with RESP.
- Reset values: all gnt/rvalid/err = 0, all rdata = 0, mem_write_o = mem_read_o = 0, mem_addr_o = mem_wdata_o = 0, FSM = IDLE, pointer = port 1.
- Reset mid-ACCESS: mem_write_o drops asynchronously, so no write occurs. The pending response is discarded.
- Simultaneous gnt to one port and rvalid to the other in RESP is legal.

## Configuration
- DMEM_ARB_RANGE_CHECK_EN defined: range/alignment check active; err_o as described.
- Not defined: every access goes to memory; m0_err_o/m1_err_o tied to 0; no comparator logic.

## Test plan
- Reset, then port 0 writes 0xDEADBEEF to 0x10010004 and later reads it back. Required: gnt, then mem_write_o for exactly one cycle, then rvalid two cycles after gnt, then rdata = 0xDEADBEEF with err = 0.
- Both ports request in the same cycle after reset, held continuously. Required: grants alternate port 0, port 1, port 0, with gnts two cycles apart.
- With the check enabled, port 1 reads 0x10018000 and 0x10010002. Required: rvalid with err = 1, rdata = 0, mem_read_o never asserted.
- Same accesses with the macro undefined. Required: err = 0, mem_read_o asserted in ACCESS.
- Assert reset during ACCESS of a write of 0x12345678 to 0x10010010. Required: mem_write_o falls immediately, no rvalid, and a subsequent read of that address returns its old value.
- Port 0 requests in the RESP cycle of a port 1 read. Required: m0_gnt_o and m1_rvalid_o are both high in that cycle, and port 1 rdata is correct.

Source files
------------

// File: rtl/data_memory_arbiter.sv
// data_memory_arbiter: round-robin two-master arbiter and sequencer for the single-port data memory.
// Define DMEM_ARB_RANGE_CHECK_EN to reject out-of-window or misaligned accesses.
module data_memory_arbiter #(
  parameter int DATA_WIDTH = 32,
  parameter logic [DATA_WIDTH-1:0] BASE_ADDR = 32'h10010000,
  parameter int unsigned MEM_BYTES = 32768
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  m0_req_i,
  input  logic                  m0_we_i,
  input  logic [DATA_WIDTH-1:0] m0_addr_i,
  input  logic [DATA_WIDTH-1:0] m0_wdata_i,
  output logic                  m0_gnt_o,
  output logic                  m0_rvalid_o,
  output logic                  m0_err_o,
  output logic [DATA_WIDTH-1:0] m0_rdata_o,
  input  logic                  m1_req_i,
  input  logic                  m1_we_i,
  input  logic [DATA_WIDTH-1:0] m1_addr_i,
  input  logic [DATA_WIDTH-1:0] m1_wdata_i,
  output logic                  m1_gnt_o,
  output logic                  m1_rvalid_o,
  output logic                  m1_err_o,
  output logic [DATA_WIDTH-1:0] m1_rdata_o,
  output logic                  mem_write_o,
  output logic                  mem_read_o,
  output logic [DATA_WIDTH-1:0] mem_addr_o,
  output logic [DATA_WIDTH-1:0] mem_wdata_o,
  input  logic [DATA_WIDTH-1:0] mem_rdata_i
);
  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;
  state_t state_q;
  logic owner_q, we_q, err_q;
  logic [DATA_WIDTH-1:0] addr_q, wdata_q, rdata_q;
  logic take, win, in_access, bad;
  // owner_q doubles as the round-robin pointer: the last granted port loses the next tie
  assign take = state_q != ACCESS && (m0_req_i || m1_req_i);
  assign win = (m0_req_i && m1_req_i) ? ~owner_q : m1_req_i;
  assign m0_gnt_o = take && !win;
  assign m1_gnt_o = take && win;
`ifdef DMEM_ARB_RANGE_CHECK_EN
  localparam logic [DATA_WIDTH-1:0] LIMIT = BASE_ADDR + DATA_WIDTH'(MEM_BYTES);
  assign bad = addr_q < BASE_ADDR || addr_q >= LIMIT || addr_q[1:0] != 2'b00;
`else
  logic unused_cfg;
  assign unused_cfg = ^{BASE_ADDR, MEM_BYTES};
  assign bad = 1'b0;
`endif
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= IDLE;
      owner_q <= 1'b1;
      we_q <= 1'b0;
      addr_q <= '0;
      wdata_q <= '0;
      err_q <= 1'b0;
      rdata_q <= '0;
    end else begin
      if (take) begin
        state_q <= ACCESS;
        owner_q <= win;
        we_q <= win ? m1_we_i : m0_we_i;
        addr_q <= win ? m1_addr_i : m0_addr_i;
        wdata_q <= win ? m1_wdata_i : m0_wdata_i;
      end else begin
        state_q <= state_q == ACCESS ? RESP : IDLE;
      end
      if (in_access) begin
        err_q <= bad;
        rdata_q <= (we_q || bad) ? '0 : mem_rdata_i;
      end
    end
  end
  // mem strobes decode straight from state so an async reset kills an in-flight write
  assign in_access = state_q == ACCESS;
  assign mem_write_o = in_access && we_q && !bad;
  assign mem_read_o = in_access && !we_q && !bad;
  assign mem_addr_o = in_access ? addr_q : '0;
  assign mem_wdata_o = in_access ? wdata_q : '0;
  assign m0_rvalid_o = state_q == RESP && !owner_q;
  assign m1_rvalid_o = state_q == RESP && owner_q;
  assign m0_err_o = m0_rvalid_o && err_q;
  assign m1_err_o = m1_rvalid_o && err_q;
  assign m0_rdata_o = m0_rvalid_o ? rdata_q : '0;
  assign m1_rdata_o = m1_rvalid_o ? rdata_q : '0;
endmodule

// File: tb/tb_data_memory_arbiter.sv
// tb_data_memory_arbiter: directed and randomized checks of data_memory_arbiter against a transaction-level model.
module tb_data_memory_arbiter;
  localparam logic [31:0] BASE = 32'h10010000;
  localparam logic [31:0] LIMIT = 32'h10018000;
`ifdef DMEM_ARB_RANGE_CHECK_EN
  localparam bit CHK = 1'b1;
`else
  localparam bit CHK = 1'b0;
`endif
  logic clk = 1'b0, reset = 1'b0, mem_clear = 1'b0;
  logic m0_req = 0, m0_we = 0, m1_req = 0, m1_we = 0;
  logic [31:0] m0_addr = 0, m0_wdata = 0, m1_addr = 0, m1_wdata = 0;
  logic m0_gnt, m0_rvalid, m0_err, m1_gnt, m1_rvalid, m1_err;
  logic [31:0] m0_rdata, m1_rdata;
  logic mem_write_o, mem_read_o;
  logic [31:0] mem_addr_o, mem_wdata_o, mem_rdata;
  logic [31:0] mem [0:8191];
  logic [31:0] ref_mem [int];
  int n_pass = 0, n_fail = 0, n_total = 0;

  always #5 clk = ~clk;

  data_memory_arbiter dut (
    .clk(clk), .reset(reset),
    .m0_req_i(m0_req), .m0_we_i(m0_we), .m0_addr_i(m0_addr), .m0_wdata_i(m0_wdata),
    .m0_gnt_o(m0_gnt), .m0_rvalid_o(m0_rvalid), .m0_err_o(m0_err), .m0_rdata_o(m0_rdata),
    .m1_req_i(m1_req), .m1_we_i(m1_we), .m1_addr_i(m1_addr), .m1_wdata_i(m1_wdata),
    .m1_gnt_o(m1_gnt), .m1_rvalid_o(m1_rvalid), .m1_err_o(m1_err), .m1_rdata_o(m1_rdata),
    .mem_write_o(mem_write_o), .mem_read_o(mem_read_o), .mem_addr_o(mem_addr_o),
    .mem_wdata_o(mem_wdata_o), .mem_rdata_i(mem_rdata)
  );

  // word-addressed data memory; the window aliases on addr[14:2]
  assign mem_rdata = mem[mem_addr_o[14:2]];
  always @(posedge clk)
    if (mem_clear) for (int i = 0; i < 8192; i++) mem[i] <= '0;
    else if (mem_write_o) mem[mem_addr_o[14:2]] <= mem_wdata_o;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_total++;
    assert (obs === exp) n_pass++;
    else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic bit is_bad(input logic [31:0] a);
    return CHK && (a < BASE || a >= LIMIT || a[1:0] != 2'b00);
  endfunction
  function automatic logic [31:0] ref_rd(input logic [31:0] a);
    return ref_mem.exists(int'(a[14:2])) ? ref_mem[int'(a[14:2])] : 32'h0;
  endfunction
  function automatic logic gnt_of(input int p); return p == 1 ? m1_gnt : m0_gnt; endfunction
  function automatic logic rv_of(input int p); return p == 1 ? m1_rvalid : m0_rvalid; endfunction
  function automatic logic err_of(input int p); return p == 1 ? m1_err : m0_err; endfunction
  function automatic logic [31:0] rd_of(input int p); return p == 1 ? m1_rdata : m0_rdata; endfunction

  task automatic step(); @(posedge clk); #2; endtask
  task automatic drive(input int p, input logic r, input logic w, input logic [31:0] a, input logic [31:0] d);
    if (p == 1) begin m1_req = r; m1_we = w; m1_addr = a; m1_wdata = d; end
    else begin m0_req = r; m0_we = w; m0_addr = a; m0_wdata = d; end
  endtask
  task automatic reset_pulse();
    drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0);
    reset = 1'b0; #1;
    step();
    reset = 1'b1;
    step();
  endtask

  // one complete transaction with per-phase checks; expectations come from the reference model
  task automatic access(input int p, input logic w, input logic [31:0] a, input logic [31:0] d);
    int n;
    bit e;
    logic [31:0] er;
    n = 0;
    e = is_bad(a);
    er = (w || e) ? 32'h0 : ref_rd(a);
    drive(p, 1, w, a, d); #1;
    while (!gnt_of(p) && n < 20) begin step(); #1; n++; end
    chk("gnt", 32'(gnt_of(p)), 1);
    if (w && !e) ref_mem[int'(a[14:2])] = d;
    step(); drive(p, 0, 0, 0, 0); #1;
    chk("access_write", 32'(mem_write_o), 32'(w && !e));
    chk("access_read", 32'(mem_read_o), 32'(!w && !e));
    chk("access_addr", mem_addr_o, a);
    chk("access_rvalid_early", 32'(rv_of(p)), 0);
    step(); #1;
    chk("resp_rvalid", 32'(rv_of(p)), 1);
    chk("resp_other_rvalid", 32'(rv_of(1 - p)), 0);
    chk("resp_err", 32'(err_of(p)), 32'(e));
    chk("resp_rdata", rd_of(p), er);
    chk("resp_mem_idle", 32'({mem_write_o, mem_read_o}), 0);
  endtask

  initial begin
    logic rq [2];
    logic rw [2];
    logic [31:0] ra [2];
    logic [31:0] rdw [2];
    bit gs [2];
    int last, pp, pc, ew;
    bit pv, pe, prev_g, eg;
    logic [31:0] pr;
    // reset values
    mem_clear = 1'b1;
    step(); step(); #1;
    chk("rst_ctrl", 32'({m0_gnt, m1_gnt, m0_rvalid, m1_rvalid, m0_err, m1_err, mem_write_o, mem_read_o}), 0);
    chk("rst_rdata", m0_rdata | m1_rdata, 0);
    chk("rst_mem_bus", mem_addr_o | mem_wdata_o, 0);
    mem_clear = 1'b0;
    reset = 1'b1;
    step();
    // write then read back
    access(0, 1, 32'h10010004, 32'hDEADBEEF);
    step();
    access(0, 0, 32'h10010004, 0);
    // continuous tie after reset: 0, 1, 0 two cycles apart
    reset_pulse();
    drive(0, 1, 0, BASE + 8, 0); drive(1, 1, 0, BASE + 12, 0); #1;
    for (int c = 0; c < 6; c++) begin
      chk("tie_gnt0", 32'(m0_gnt), 32'(c == 0 || c == 4));
      chk("tie_gnt1", 32'(m1_gnt), 32'(c == 2));
      step(); #1;
    end
    drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0);
    step(); step();
    // window and alignment boundaries
    access(1, 0, LIMIT, 0);
    access(1, 0, 32'h10010002, 0);
    access(1, 0, BASE - 4, 0);
    access(1, 0, LIMIT - 4, 0);
    // reset during the ACCESS cycle of a write
    access(0, 1, BASE + 16, 32'hA5A5A5A5);
    drive(0, 1, 1, BASE + 16, 32'h12345678); #1;
    chk("rst_mid_gnt", 32'(m0_gnt), 1);
    step(); drive(0, 0, 0, 0, 0); #1;
    chk("rst_mid_write_before", 32'(mem_write_o), 1);
    reset = 1'b0; #1;
    chk("rst_mid_write_drop", 32'(mem_write_o), 0);
    for (int c = 0; c < 3; c++) begin
      step(); #1;
      chk("rst_mid_no_rvalid", 32'({m0_rvalid, m1_rvalid}), 0);
    end
    reset = 1'b1;
    step();
    access(0, 0, BASE + 16, 0);
    // port 0 granted in the RESP cycle of a port 1 read
    drive(1, 1, 0, 32'h10010004, 0); #1;
    chk("ovl_gnt1", 32'(m1_gnt), 1);
    step(); drive(1, 0, 0, 0, 0); #1;
    step(); drive(0, 1, 1, BASE + 20, 32'hCAFEF00D); #1;
    chk("ovl_gnt0", 32'(m0_gnt), 1);
    chk("ovl_rvalid1", 32'(m1_rvalid), 1);
    chk("ovl_rdata1", m1_rdata, ref_rd(32'h10010004));
    ref_mem[int'(BASE[14:2]) + 5] = 32'hCAFEF00D;
    step(); drive(0, 0, 0, 0, 0); #1;
    chk("ovl_write0", 32'(mem_write_o), 1);
    step(); #1;
    chk("ovl_rvalid0", 32'({m0_rvalid, m1_rvalid}), 32'b10);
    step();
    access(1, 0, BASE + 20, 0);
    // randomized traffic against the transaction-level model
    reset_pulse();
    last = 1; pv = 0; pc = 0; pp = 0; pe = 0; pr = 0; prev_g = 0;
    for (int p = 0; p < 2; p++) begin rq[p] = 0; rw[p] = 0; ra[p] = 0; rdw[p] = 0; gs[p] = 0; end
    for (int c = 0; c < 600; c++) begin
      step();
      for (int p = 0; p < 2; p++) begin
        if (rq[p] && gs[p]) rq[p] = 0;
        if (!rq[p] && $urandom_range(0, 2) == 0) begin
          rq[p] = 1;
          rw[p] = $urandom_range(0, 1) == 1;
          rdw[p] = $urandom;
          ra[p] = BASE + 4 * $urandom_range(0, 15);
          if (!rw[p] && $urandom_range(0, 4) == 0)
            case ($urandom_range(0, 2))
              0: ra[p] = LIMIT + 4 * $urandom_range(0, 3);
              1: ra[p] = BASE - 4;
              default: ra[p] = BASE + 4 * $urandom_range(0, 15) + $urandom_range(1, 3);
            endcase
        end
        drive(p, rq[p], rw[p], ra[p], rdw[p]);
      end
      #1;
      if (pv) pc--;
      for (int p = 0; p < 2; p++) chk("rnd_rvalid", 32'(rv_of(p)), 32'(pv && pc == 0 && pp == p));
      if (pv && pc == 0) begin
        chk("rnd_err", 32'(err_of(pp)), 32'(pe));
        chk("rnd_rdata", rd_of(pp), pr);
        pv = 0;
      end
      eg = !prev_g && (rq[0] || rq[1]);
      ew = (rq[0] && rq[1]) ? 1 - last : (rq[1] ? 1 : 0);
      for (int p = 0; p < 2; p++) begin
        chk("rnd_gnt", 32'(gnt_of(p)), 32'(eg && ew == p));
        gs[p] = gnt_of(p);
      end
      if (eg) begin
        last = ew;
        pe = is_bad(ra[ew]);
        pr = (rw[ew] || pe) ? 32'h0 : ref_rd(ra[ew]);
        if (rw[ew] && !pe) ref_mem[int'(ra[ew][14:2])] = rdw[ew];
        pv = 1; pc = 2; pp = ew;
      end
      prev_g = eg;
    end
    drive(0, 0, 0, 0, 0); drive(1, 0, 0, 0, 0);
    step(); step(); step();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
